// File: rtl/lc4_trace_pkg.sv
// Shared definitions for the LC4 commit trace recorder: stall codes,
// fixed field widths, record bit offsets and a saturating counter helper.
package lc4_trace_pkg;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_CACHE  = 2'd1,
    STALL_BRANCH = 2'd2,
    STALL_LOAD   = 2'd3
  } stall_e;

  localparam int PC_W    = 16;
  localparam int INSN_W  = 16;
  localparam int WSEL_W  = 3;
  localparam int NZP_W   = 3;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 32;
  localparam int FIXED_W = PC_W + INSN_W + 1 + WSEL_W + 1 + NZP_W + 1 + ADDR_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Record layout, MSB first: pc, insn, rf_we, wsel, rf_data, nzp_we,
  // nzp_bits, dmem_we, dmem_addr, dmem_data. Offsets are LSB positions.
  function automatic int rec_width(int w);     return FIXED_W + 2*w;  endfunction
  function automatic int off_dmem_addr(int w); return w;              endfunction
  function automatic int off_dmem_we(int w);   return w + 16;         endfunction
  function automatic int off_nzp_bits(int w);  return w + 17;         endfunction
  function automatic int off_nzp_we(int w);    return w + 20;         endfunction
  function automatic int off_rf_data(int w);   return w + 21;         endfunction
  function automatic int off_wsel(int w);      return 2*w + 21;       endfunction
  function automatic int off_rf_we(int w);     return 2*w + 24;       endfunction
  function automatic int off_insn(int w);      return 2*w + 25;       endfunction
  function automatic int off_pc(int w);        return 2*w + 41;       endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lc4_trace_fifo.sv
// Record FIFO: registered storage, no bypass; an empty FIFO shows zero data.
module lc4_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while not covered by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lc4_trace_recorder.sv
// LC4 commit trace recorder: captures committed instructions into a FIFO
// and counts commit/stall events. Define LC4_TRACE_STALL_COUNT_EN to get
// live cnt_cache/cnt_branch/cnt_load; otherwise they read as zero.
module lc4_trace_recorder
  import lc4_trace_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gwe,
  input  logic                       rec_en,
  input  logic [1:0]                 test_stall,
  input  logic [15:0]                test_cur_pc,
  input  logic [15:0]                test_cur_insn,
  input  logic                       test_regfile_we,
  input  logic [2:0]                 test_regfile_wsel,
  input  logic [WORD_SIZE-1:0]       test_regfile_data,
  input  logic                       test_nzp_we,
  input  logic [2:0]                 test_nzp_new_bits,
  input  logic                       test_dmem_we,
  input  logic [15:0]                test_dmem_addr,
  input  logic [WORD_SIZE-1:0]       test_dmem_data,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [57+2*WORD_SIZE-1:0]  rec_data,
  output logic [31:0]                cnt_exec,
  output logic [31:0]                cnt_cache,
  output logic [31:0]                cnt_branch,
  output logic [31:0]                cnt_load,
  output logic [31:0]                cnt_drop,
  output logic                       overflow
);
  localparam int REC_W = rec_width(WORD_SIZE);

  logic             commit, cap, pop, push, drop, full, empty;
  logic [REC_W-1:0] rec_in;

  assign commit = rst && gwe && rec_en;
  assign cap    = commit && (test_stall == STALL_NONE);
  assign pop    = rec_valid && rec_ready;
  assign push   = cap && (!full || pop);
  assign drop   = cap && full && !pop;

  // Pack the record; register/NZP payloads are masked when not written.
  always_comb begin
    rec_in = '0;
    rec_in[off_pc(WORD_SIZE)        +: PC_W]      = test_cur_pc;
    rec_in[off_insn(WORD_SIZE)      +: INSN_W]    = test_cur_insn;
    rec_in[off_rf_we(WORD_SIZE)]                  = test_regfile_we;
    rec_in[off_wsel(WORD_SIZE)      +: WSEL_W]    = test_regfile_we ? test_regfile_wsel : '0;
    rec_in[off_rf_data(WORD_SIZE)   +: WORD_SIZE] = test_regfile_we ? test_regfile_data : '0;
    rec_in[off_nzp_we(WORD_SIZE)]                 = test_nzp_we;
    rec_in[off_nzp_bits(WORD_SIZE)  +: NZP_W]     = test_nzp_we ? test_nzp_new_bits : '0;
    rec_in[off_dmem_we(WORD_SIZE)]                = test_dmem_we;
    rec_in[off_dmem_addr(WORD_SIZE) +: ADDR_W]    = test_dmem_addr;
    rec_in[WORD_SIZE-1:0]                         = test_dmem_data;
  end

  lc4_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rec_in),
    .pop   (pop),
    .dout  (rec_data),
    .full  (full),
    .empty (empty)
  );

  assign rec_valid = !empty;

  // Commit and drop accounting, saturating; overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_exec <= '0;
      cnt_drop <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap)  cnt_exec <= sat_inc(cnt_exec);
      if (drop) begin
        cnt_drop <= sat_inc(cnt_drop);
        overflow <= 1'b1;
      end
    end
  end

`ifdef LC4_TRACE_STALL_COUNT_EN
  // Per-cause stall counters, saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_cache  <= '0;
      cnt_branch <= '0;
      cnt_load   <= '0;
    end else if (commit) begin
      case (test_stall)
        STALL_CACHE:  cnt_cache  <= sat_inc(cnt_cache);
        STALL_BRANCH: cnt_branch <= sat_inc(cnt_branch);
        STALL_LOAD:   cnt_load   <= sat_inc(cnt_load);
        default: ;
      endcase
    end
  end
`else
  assign cnt_cache  = '0;
  assign cnt_branch = '0;
  assign cnt_load   = '0;
`endif

endmodule

// File: tb/tb_lc4_trace_recorder.sv
// Directed bench for lc4_trace_recorder (WORD_SIZE=64, DEPTH=8).
module tb_lc4_trace_recorder;
  localparam int W  = 64;
  localparam int RW = 57 + 2*W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          gwe = 1'b0, rec_en = 1'b0, rec_ready = 1'b0;
  logic [1:0]    test_stall = 2'd0;
  logic [15:0]   test_cur_pc = '0, test_cur_insn = '0, test_dmem_addr = '0;
  logic          test_regfile_we = 1'b0, test_nzp_we = 1'b0, test_dmem_we = 1'b0;
  logic [2:0]    test_regfile_wsel = '0, test_nzp_new_bits = '0;
  logic [W-1:0]  test_regfile_data = '0, test_dmem_data = '0;
  logic          rec_valid, overflow;
  logic [RW-1:0] rec_data;
  logic [31:0]   cnt_exec, cnt_cache, cnt_branch, cnt_load, cnt_drop;

  int checks = 0;
  int failures = 0;
  int n;
  logic [15:0] last_pc;
  logic [31:0] exp_stall;

  lc4_trace_recorder #(.WORD_SIZE(W), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .rec_en(rec_en), .test_stall(test_stall),
    .test_cur_pc(test_cur_pc), .test_cur_insn(test_cur_insn),
    .test_regfile_we(test_regfile_we), .test_regfile_wsel(test_regfile_wsel),
    .test_regfile_data(test_regfile_data), .test_nzp_we(test_nzp_we),
    .test_nzp_new_bits(test_nzp_new_bits), .test_dmem_we(test_dmem_we),
    .test_dmem_addr(test_dmem_addr), .test_dmem_data(test_dmem_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .cnt_exec(cnt_exec), .cnt_cache(cnt_cache), .cnt_branch(cnt_branch),
    .cnt_load(cnt_load), .cnt_drop(cnt_drop), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; gwe = 1'b0; rec_en = 1'b0; rec_ready = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic commit(input logic [15:0] pc, input logic [1:0] stall);
    test_cur_pc = pc; test_stall = stall; gwe = 1'b1; rec_en = 1'b1;
    step();
    gwe = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_data", rec_data, '0);
    chk("rst_exec", cnt_exec, 32'd0);
    chk("rst_drop", cnt_drop, 32'd0);
    chk("rst_ovf", overflow, 1'b0);

    // Single exec commit; field positions hand-computed for W=64
    test_cur_insn = 16'h9201; test_regfile_we = 1'b1; test_regfile_wsel = 3'd1;
    test_regfile_data = 64'd1;
    commit(16'h8200, 2'd0);
    chk("one_valid", rec_valid, 1'b1);
    chk("one_pc", rec_data[184:169], 16'h8200);
    chk("one_insn", rec_data[168:153], 16'h9201);
    chk("one_rfwe", rec_data[152], 1'b1);
    chk("one_wsel", rec_data[151:149], 3'd1);
    chk("one_rfdata", rec_data[148:85], 64'd1);
    chk("one_low", rec_data[84:0], '0);
    chk("one_exec", cnt_exec, 32'd1);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    chk("one_popped", rec_valid, 1'b0);

    // Masking: wsel/rf_data/nzp_bits zeroed, dmem fields pass through
    test_regfile_we = 1'b0; test_regfile_wsel = 3'd5; test_regfile_data = 64'hDEAD_BEEF_0000_1111;
    test_nzp_we = 1'b0; test_nzp_new_bits = 3'b011; test_dmem_we = 1'b0;
    test_dmem_addr = 16'h1234; test_dmem_data = 64'hCAFE_0000_0000_0042;
    test_cur_insn = 16'h0000;
    commit(16'h0010, 2'd0);
    chk("mask_rec", rec_data,
        {16'h0010, 16'h0000, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 1'b0, 16'h1234, 64'hCAFE_0000_0000_0042});
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    test_nzp_we = 1'b1; test_dmem_we = 1'b1;
    commit(16'h0011, 2'd0);
    chk("nzp_rec", rec_data,
        {16'h0011, 16'h0000, 1'b0, 3'd0, 64'd0, 1'b1, 3'b011, 1'b1, 16'h1234, 64'hCAFE_0000_0000_0042});
    test_nzp_we = 1'b0; test_dmem_we = 1'b0; test_dmem_addr = '0; test_dmem_data = '0;
    test_regfile_data = '0; test_regfile_wsel = '0;

    // Stall sequence 1,2,3,0
    do_reset();
    commit(16'h0100, 2'd1);
    commit(16'h0101, 2'd2);
    commit(16'h0102, 2'd3);
    commit(16'h0103, 2'd0);
`ifdef LC4_TRACE_STALL_COUNT_EN
    exp_stall = 32'd1;
`else
    exp_stall = 32'd0;
`endif
    chk("stall_cache", cnt_cache, exp_stall);
    chk("stall_branch", cnt_branch, exp_stall);
    chk("stall_load", cnt_load, exp_stall);
    chk("stall_exec", cnt_exec, 32'd1);
    chk("stall_pc", rec_data[184:169], 16'h0103);
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    chk("stall_one_rec", rec_valid, 1'b0);

    // Overflow: 10 commits into DEPTH=8 with consumer stalled
    do_reset();
    for (int i = 0; i < 10; i++) commit(16'h1000 + 16'(i), 2'd0);
    chk("ovf_drop", cnt_drop, 32'd2);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_exec", cnt_exec, 32'd10);
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order_valid", rec_valid, 1'b1);
      chk("ovf_order_pc", rec_data[184:169], 16'h1000 + 16'(i));
      step();
    end
    rec_ready = 1'b0;
    chk("ovf_drained", rec_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 8; i++) commit(16'h2000 + 16'(i), 2'd0);
    rec_ready = 1'b1;
    commit(16'h2100, 2'd0);
    rec_ready = 1'b0;
    chk("full_pp_drop", cnt_drop, 32'd2);
    chk("full_pp_head", rec_data[184:169], 16'h2001);
    rec_ready = 1'b1;
    n = 0; last_pc = '0;
    while (rec_valid && n < 20) begin
      last_pc = rec_data[184:169];
      n++;
      step();
    end
    rec_ready = 1'b0;
    chk("full_pp_occ", n, 8);
    chk("full_pp_last", last_pc, 16'h2100);

    // gwe=0 and rec_en=0 ignore all inputs
    do_reset();
    test_stall = 2'd0; rec_en = 1'b1; gwe = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rec_en = 1'b0; gwe = 1'b1;
    for (int i = 0; i < 3; i++) step();
    gwe = 1'b0;
    chk("idle_valid", rec_valid, 1'b0);
    chk("idle_exec", cnt_exec, 32'd0);
    chk("idle_cnts", {cnt_cache, cnt_branch, cnt_load, cnt_drop}, '0);

    // Reset with queued records; overflow set beforehand
    for (int i = 0; i < 9; i++) commit(16'h3000 + 16'(i), 2'd0);
    chk("pre_rst_ovf", overflow, 1'b1);
    rst = 1'b0; gwe = 1'b1; rec_en = 1'b1; test_stall = 2'd0; test_cur_pc = 16'h3FFF;
    step();
    chk("mid_rst_valid", rec_valid, 1'b0);
    chk("mid_rst_exec", cnt_exec, 32'd0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_data", rec_data, '0);
    rst = 1'b1; gwe = 1'b0;
    step();
    chk("post_rst_valid", rec_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
